// File: rtl/mac_sequencer_pkg.sv
// Shared fixed-point format and controller state type for the MAC sequencer.
package mac_sequencer_pkg;

   localparam int unsigned Q_INT   = 8;
   localparam int unsigned Q_FRAC  = 8;
   localparam int unsigned Q_DEPTH = Q_INT + Q_FRAC;

   typedef logic signed [Q_INT-1:-Q_FRAC] q_t;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDrain,
      StOut
   } mac_seq_state_e;

endpackage

// File: rtl/mac_sequencer.sv
// Steps an external MacUnit through one dot product, reading x/w from 1-cycle RAMs,
// and hands the saturated sum out on a valid/ready port.
module mac_sequencer
   import mac_sequencer_pkg::*;
#(
   parameter int unsigned ADDR_W = 10,
   parameter int unsigned LEN_W  = 10
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               abort,
   input  logic [LEN_W-1:0]   len,
   input  logic [ADDR_W-1:0]  x_base,
   input  logic [ADDR_W-1:0]  w_base,
   output logic               busy,
   output logic               mem_rd_en,
   output logic [ADDR_W-1:0]  x_addr,
   output logic [ADDR_W-1:0]  w_addr,
   output logic               mac_acc_loopback,
   output logic               mac_acc_update,
   input  logic [Q_DEPTH-1:0] mac_in,
   output logic [Q_DEPTH-1:0] result,
   output logic               result_valid,
   input  logic               result_ready,
   output logic               done
);

   mac_seq_state_e    state_q, state_d;
   logic [LEN_W-1:0]  idx_q, idx_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [ADDR_W-1:0] xb_q, xb_d;
   logic [ADDR_W-1:0] wb_q, wb_d;
   logic              valid_q, valid_d;
   logic              loop_q, loop_d;
   q_t                result_q, result_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         idx_q    <= '0;
         len_q    <= '0;
         xb_q     <= '0;
         wb_q     <= '0;
         valid_q  <= 1'b0;
         loop_q   <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         len_q    <= len_d;
         xb_q     <= xb_d;
         wb_q     <= wb_d;
         valid_q  <= valid_d;
         loop_q   <= loop_d;
         result_q <= result_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      len_d        = len_q;
      xb_d         = xb_q;
      wb_d         = wb_q;
      valid_d      = 1'b0;
      loop_d       = 1'b0;
      result_d     = result_q;
      mem_rd_en    = 1'b0;
      x_addr       = '0;
      w_addr       = '0;
      result_valid = 1'b0;
      done         = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (start && !abort) begin
               if (len != '0) begin
                  len_d   = len;
                  xb_d    = x_base;
                  wb_d    = w_base;
                  idx_d   = '0;
                  state_d = StRun;
               end else begin
                  result_d = '0;
                  state_d  = StOut;
               end
            end
         end
         StRun: begin
            mem_rd_en = 1'b1;
            x_addr    = xb_q + ADDR_W'(idx_q);
            w_addr    = wb_q + ADDR_W'(idx_q);
            // Element 0 must not fold in whatever the MacUnit accumulator still holds.
            valid_d   = 1'b1;
            loop_d    = (idx_q != '0);
            if (idx_q == len_q - LEN_W'(1)) begin
               state_d = StDrain;
            end else begin
               idx_d = idx_q + LEN_W'(1);
            end
            if (abort) begin
               valid_d = 1'b0;
               loop_d  = 1'b0;
               state_d = StIdle;
            end
         end
         StDrain: begin
            if (abort) begin
               state_d = StIdle;
            end else begin
               result_d = q_t'(mac_in);
               state_d  = StOut;
            end
         end
         StOut: begin
            result_valid = 1'b1;
            if (abort) begin
               state_d = StIdle;
            end else if (result_ready) begin
               done    = 1'b1;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign busy             = (state_q != StIdle);
   assign mac_acc_update   = valid_q;
   assign mac_acc_loopback = loop_q;
   assign result           = result_q;

endmodule

// File: tb/tb_mac_sequencer.sv
// Sequencer + behavioural MacUnit and 1-cycle RAMs; results compared to a plain dot-product model.
module tb_mac_sequencer;
   import mac_sequencer_pkg::*;

   localparam int unsigned ADDR_W = 10;
   localparam int unsigned LEN_W  = 10;
   localparam int unsigned MEM_N  = 1 << ADDR_W;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               start = 1'b0;
   logic               abort = 1'b0;
   logic [LEN_W-1:0]   len = '0;
   logic [ADDR_W-1:0]  x_base = '0;
   logic [ADDR_W-1:0]  w_base = '0;
   logic               busy, mem_rd_en, mac_acc_loopback, mac_acc_update;
   logic [ADDR_W-1:0]  x_addr, w_addr;
   logic [Q_DEPTH-1:0] mac_in, result;
   logic               result_valid, done;
   logic               result_ready = 1'b0;

   logic [15:0] xmem [MEM_N];
   logic [15:0] wmem [MEM_N];
   logic [15:0] x_rd, w_rd, acc;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mac_sequencer #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .start            (start),
      .abort            (abort),
      .len              (len),
      .x_base           (x_base),
      .w_base           (w_base),
      .busy             (busy),
      .mem_rd_en        (mem_rd_en),
      .x_addr           (x_addr),
      .w_addr           (w_addr),
      .mac_acc_loopback (mac_acc_loopback),
      .mac_acc_update   (mac_acc_update),
      .mac_in           (mac_in),
      .result           (result),
      .result_valid     (result_valid),
      .result_ready     (result_ready),
      .done             (done)
   );

   function automatic logic [15:0] sat16(input longint v);
      if (v > 32767) return 16'h7fff;
      if (v < -32768) return 16'h8000;
      return v[15:0];
   endfunction

   function automatic logic [15:0] qmul(input logic [15:0] a, input logic [15:0] b);
      longint p;
      p = longint'($signed(a)) * longint'($signed(b));
      return sat16(p >>> Q_FRAC);
   endfunction

   // Synchronous RAMs, one cycle read latency.
   always @(posedge clk) begin
      if (mem_rd_en) begin
         x_rd <= xmem[x_addr];
         w_rd <= wmem[w_addr];
      end
   end

   // Behavioural MacUnit: mac = sat(sat(x*w) + (loopback ? acc : 0)).
   always_comb begin
      longint s;
      s = longint'($signed(qmul(x_rd, w_rd)));
      if (mac_acc_loopback) s = s + longint'($signed(acc));
      mac_in = sat16(s);
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) acc <= '0;
      else if (mac_acc_update) acc <= mac_in;
   end

   function automatic logic [15:0] ref_dot(input int n, input int xb, input int wb);
      longint a;
      a = 0;
      for (int i = 0; i < n; i++) begin
         a = longint'($signed(sat16(a + longint'($signed(
                 qmul(xmem[(xb + i) % MEM_N], wmem[(wb + i) % MEM_N]))))));
      end
      return a[15:0];
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_op(input int n, input int xb, input int wb, input int ready_delay,
                         input bit poke_start);
      int          cyc, rds, upd;
      logic [15:0] exp;
      exp    = ref_dot(n, xb, wb);
      start  = 1'b1;
      len    = LEN_W'(n);
      x_base = ADDR_W'(xb);
      w_base = ADDR_W'(wb);
      tick();
      start = 1'b0;
      cyc = 1;
      rds = 0;
      upd = 0;
      while (!result_valid && cyc < n + 10) begin
         if (mem_rd_en) begin
            check("x_addr", 32'(x_addr), 32'((xb + rds) % MEM_N));
            check("w_addr", 32'(w_addr), 32'((wb + rds) % MEM_N));
            rds++;
         end
         if (mac_acc_update) begin
            check("loopback", 32'(mac_acc_loopback), 32'(upd != 0));
            upd++;
         end
         tick();
         cyc++;
      end
      check("result_valid_timeout", 32'(result_valid), 32'd1);
      check("latency", 32'(cyc), (n == 0) ? 32'd1 : 32'(n + 2));
      check("rd_count", 32'(rds), 32'(n));
      check("upd_count", 32'(upd), 32'(n));
      check("result", 32'(result), 32'(exp));
      for (int d = 0; d < ready_delay; d++) begin
         if (poke_start && d == 0) start = 1'b1;
         if (poke_start && d == 0) len = LEN_W'(5);
         #1;
         check("done_early", 32'(done), 32'd0);
         tick();
         start = 1'b0;
         check("held_valid", 32'(result_valid), 32'd1);
         check("held_result", 32'(result), 32'(exp));
      end
      result_ready = 1'b1;
      #1;
      check("done_pulse", 32'(done), 32'd1);
      tick();
      result_ready = 1'b0;
      check("valid_drop", 32'(result_valid), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
      check("done_clear", 32'(done), 32'd0);
   endtask

   initial begin
      for (int i = 0; i < int'(MEM_N); i++) begin
         xmem[i] = 16'($urandom_range(0, 16'hffff));
         wmem[i] = 16'($urandom_range(0, 16'hffff));
      end
      xmem[0] = 16'h0100; xmem[1] = 16'h0200; xmem[2] = 16'h0080;
      wmem[0] = 16'h0080; wmem[1] = 16'h0040; wmem[2] = 16'h0200;
      for (int i = 200; i < 204; i++) xmem[i] = 16'h7fff;
      for (int i = 300; i < 304; i++) wmem[i] = 16'h7fff;
      xmem[100] = 16'h0180; wmem[100] = 16'h0200;

      #12;
      check("reset_outputs",
            {22'd0, busy, mem_rd_en, mac_acc_loopback, mac_acc_update, result_valid, done,
             |x_addr, |w_addr, |result, 1'b0}, 32'd0);
      rst_n = 1'b1;
      tick();

      // Basic: 1*0.5 + 2*0.25 + 0.5*2 = 2.0
      check("basic_model", 32'(ref_dot(3, 0, 0)), 32'h0200);
      run_op(3, 0, 0, 0, 1'b0);

      // Zero length
      run_op(0, 0, 0, 0, 1'b0);

      // Backpressure with start poked during OUT, then len=1: 1.5*2.0 = 3.0
      run_op(3, 0, 0, 4, 1'b1);
      check("b2b_model", 32'(ref_dot(1, 100, 100)), 32'h0300);
      run_op(1, 100, 100, 0, 1'b0);

      // Saturation passthrough
      run_op(4, 200, 300, 1, 1'b0);
      check("sat_model", 32'(ref_dot(4, 200, 300)), 32'h7fff);

      // Abort at idx=2
      start = 1'b1; len = LEN_W'(8); x_base = '0; w_base = '0;
      tick();
      start = 1'b0;
      tick();
      tick();
      check("abort_idx2_addr", 32'(x_addr), 32'd2);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_update", 32'(mac_acc_update), 32'd0);
      check("abort_rd_en", 32'(mem_rd_en), 32'd0);
      for (int i = 0; i < 3; i++) begin
         check("abort_no_valid", 32'(result_valid), 32'd0);
         check("abort_no_done", 32'(done), 32'd0);
         tick();
      end
      run_op(1, 100, 100, 0, 1'b0);

      // Address wrap
      run_op(2, 1023, 1022, 0, 1'b0);

      // Asynchronous reset mid-run
      start = 1'b1; len = LEN_W'(8); x_base = 10'd5; w_base = 10'd7;
      tick();
      start = 1'b0;
      tick();
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset_outputs",
            {22'd0, busy, mem_rd_en, mac_acc_loopback, mac_acc_update, result_valid, done,
             |x_addr, |w_addr, |result, 1'b0}, 32'd0);
      #3;
      rst_n = 1'b1;
      tick();

      // Randomized operations
      for (int t = 0; t < 8; t++) begin
         run_op(int'($urandom_range(1, 12)), int'($urandom_range(0, MEM_N - 1)),
                int'($urandom_range(0, MEM_N - 1)), int'($urandom_range(0, 3)), 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
